mnk_game_engine: RTL
====================

# mnk_game_engine

Parametrised N×N, K-in-a-row game engine: the successor to the fixed 3×3 tic-tac-toe core, generalised in board size and win length. It adds turn enforcement, illegal-move rejection with status pulses, draw detection, a soft restart, and a multi-cycle win-check FSM with a ready handshake. It sits between the move source (file-driven bench or host bridge) and the board/status consumers.

## Interface
- `N`, default 3: board side; legal 3..16; elaboration error otherwise.
- `K`, default 3: cells in a row needed to win; legal 3..N; elaboration error otherwise.
- `POS_W`, derived `$clog2(N*N)`: width of `position`; not overridable.
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `move_valid`  in  1  move request; sampled only when `move_ready`=1.
- `player`  in  1  0 = X, 1 = O.
- `position`  in  POS_W  cell index, row-major (`row*N+col`).
- `restart`  in  1  synchronous soft clear to the post-reset state.
- `move_ready`  out  1  engine can accept a move.
- `move_ack`  out  1  one-cycle pulse: move accepted.
- `move_err`  out  1  one-cycle pulse: move rejected.
- `board`  out  2·N·N  cell i at `[2i+1:2i]`: 00 empty, 01 X, 10 O.
- `turn`  out  1  player expected next.
- `game_over`  out  1  game finished.
- `winner`  out  2  00 none, 01 X, 10 O, 11 draw.

## Operation
- States: IDLE, CHECK, OVER.
- Reset or `restart` (`reset_n`=0 or `restart`=1): board all 00, `turn`=0, `game_over`=0, `winner`=00, `move_ready`=1, `move_ack`=`move_err`=0, move count 0, state IDLE. Reset has priority over restart; restart over any move; both valid in any state, including mid-CHECK.
- IDLE, `move_valid`=1: rejected (`move_err`) if `position` ≥ N·N, cell occupied, or `player`≠`turn`; board, turn and count unchanged, stay IDLE. Otherwise write cell, latch position as origin, increment count, toggle `turn`, pulse `move_ack`, enter CHECK with direction index d=0.
- CHECK: one direction per cycle, d = 0 horizontal, 1 vertical, 2 diagonal (+row,+col), 3 anti-diagonal (+row,−col). Run length = 1 + matching cells of the mover stepping both ways from origin, at most K−1 steps per side, stopping at the board edge or a non-matching cell; column wrap across rows is never a neighbour. Run ≥ K sets a sticky win flag. All four directions always evaluated (fixed latency).
- End of CHECK (d=3): win → OVER, `winner`=mover code; else count = N·N → OVER, `winner`=11; else IDLE.
- OVER: `game_over`=1, `move_ready`=0; any `move_valid` pulses `move_err`; only restart/reset leave.
- `move_valid` during CHECK: ignored, no pulse.
- Move count width `$clog2(N*N+1)`; never wraps (board fills first).

## Timing
- `move_ready`=1 only in IDLE; registered.
- Edge E0 accepts a move: after E0, `board`/`turn` updated, `move_ack`=1 for exactly one cycle, `move_ready`=0.
- Edges E1..E4 evaluate d=0..3; after E4, `game_over`/`winner` valid and `move_ready` back to 1 (unless OVER). Next move accepted no earlier than E5; throughput one move per 5 cycles.
- Rejection: `move_err` high for the one cycle following the sampling edge; `move_ready` stays 1.
- `board`, `turn`, `winner`, `game_over` are registered and stable between updates.

## Structure
- Package `mnk_pkg`: cell codes (EMPTY/X/O), winner codes (NONE/X/O/DRAW), state enum, direction index type and (dr, dc) step constants.
- Sub-module `mnk_line_counter`: combinational run counter; inputs board, origin, direction, mover code; output run length saturated at K. The engine holds the FSM, board register, count, and pulse logic.

## Test plan
- N=3,K=3: X0,O3,X1,O4,X2 → after final ack + 4 cycles, `winner`=01, `game_over`=1, `board`=18'h00295, `move_ready`=0.
- N=3: X0 then X1 (wrong turn), O0 (occupied), O9 (out of range) → three `move_err` pulses, `board`=18'h00001, `turn`=1.
- N=3 draw: X0,O1,X2,O4,X3,O5,X7,O6,X8 → `winner`=11, `game_over`=1 four cycles after the ninth ack.
- N=5,K=4: X3,O0,X7,O1,X15,O2,X11 (middle cell last) → `winner`=01 via anti-diagonal; and X4,O5,… row-edge case X3,X4 vs X5 on next row never counted as a run.
- `move_valid` held through CHECK → exactly one ack; `restart` asserted on E2 of CHECK → board 0, `turn`=0, `move_ready`=1 next cycle, no `winner` update.
- After a win, any move → `move_err`, board unchanged; `reset_n`=0 for one edge → all outputs at reset values.

Source files
------------

// File: rtl/mnk_pkg.sv
// Shared types and constants for the N x N, K-in-a-row game engine.
package mnk_pkg;

  typedef enum logic [1:0] {
    CellEmpty = 2'b00,
    CellX     = 2'b01,
    CellO     = 2'b10
  } cell_e;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinX    = 2'b01;
  localparam logic [1:0] WinO    = 2'b10;
  localparam logic [1:0] WinDraw = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StOver
  } state_e;

  typedef logic [1:0] dir_t;

  localparam dir_t DirH    = 2'd0;
  localparam dir_t DirV    = 2'd1;
  localparam dir_t DirDiag = 2'd2;
  localparam dir_t DirAnti = 2'd3;

  // Row step for a direction: horizontal stays on its row, the rest move down.
  function automatic int dir_dr(dir_t d);
    return (d == DirH) ? 0 : 1;
  endfunction

  function automatic int dir_dc(dir_t d);
    int dc;
    unique case (d)
      DirH:    dc = 1;
      DirV:    dc = 0;
      DirDiag: dc = 1;
      default: dc = -1;
    endcase
    return dc;
  endfunction

endpackage

// File: rtl/mnk_line_counter.sv
// Combinational run-length counter through an origin cell along one direction,
// saturated at K.
module mnk_line_counter
  import mnk_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned POS_W = $clog2(N*N),
  localparam int unsigned RUN_W = $clog2(K+1)
) (
  input  logic [2*N*N-1:0] board,
  input  logic [POS_W-1:0] origin,
  input  dir_t             dir,
  input  logic [1:0]       mover,
  output logic [RUN_W-1:0] run
);

  function automatic logic in_board(int r, int c);
    return (r >= 0) && (r < int'(N)) && (c >= 0) && (c < int'(N));
  endfunction

  always_comb begin
    int r0, c0, dr, dc, r, c, len;
    logic fwd_go, bwd_go;
    r0     = int'(origin) / int'(N);
    c0     = int'(origin) % int'(N);
    dr     = dir_dr(dir);
    dc     = dir_dc(dir);
    r      = 0;
    c      = 0;
    len    = 1;
    fwd_go = 1'b1;
    bwd_go = 1'b1;
    // Rows and columns are tracked separately so a column step never wraps rows.
    for (int s = 1; s < int'(K); s++) begin
      r = r0 + s * dr;
      c = c0 + s * dc;
      if (fwd_go && in_board(r, c) && (board[2*(r*int'(N)+c) +: 2] == mover)) len++;
      else fwd_go = 1'b0;
      r = r0 - s * dr;
      c = c0 - s * dc;
      if (bwd_go && in_board(r, c) && (board[2*(r*int'(N)+c) +: 2] == mover)) len++;
      else bwd_go = 1'b0;
    end
    run = (len >= int'(K)) ? RUN_W'(K) : RUN_W'(len);
  end

endmodule

// File: rtl/mnk_game_engine.sv
// N x N, K-in-a-row game engine: move validation, board state, and a
// four-cycle win check (one direction per cycle) ending in win/draw/continue.
module mnk_game_engine
  import mnk_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned K = 3,
  localparam int unsigned POS_W = $clog2(N*N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               move_valid,
  input  logic               player,
  input  logic [POS_W-1:0]   position,
  input  logic               restart,
  output logic               move_ready,
  output logic               move_ack,
  output logic               move_err,
  output logic [2*N*N-1:0]   board,
  output logic               turn,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam int unsigned CNT_W = $clog2(N*N+1);
  localparam int unsigned RUN_W = $clog2(K+1);

  if (N < 3 || N > 16) begin : g_bad_n
    $error("mnk_game_engine: N must be in 3..16");
  end
  if (K < 3 || K > N) begin : g_bad_k
    $error("mnk_game_engine: K must be in 3..N");
  end

  state_e           state_q;
  dir_t             dir_q;
  logic [POS_W-1:0] origin_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       mover_q;
  logic             win_q;

  logic [RUN_W-1:0] run;
  logic [1:0]       player_code;
  logic             illegal;
  logic             win_now;

  mnk_line_counter #(
    .N (N),
    .K (K)
  ) u_line_counter (
    .board  (board),
    .origin (origin_q),
    .dir    (dir_q),
    .mover  (mover_q),
    .run    (run)
  );

  always_comb begin
    player_code = player ? CellO : CellX;
    illegal     = (int'(position) >= int'(N*N)) ||
                  (board[2*int'(position) +: 2] != CellEmpty) ||
                  (player != turn);
    win_now     = win_q || (run == RUN_W'(K));
  end

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      state_q    <= StIdle;
      dir_q      <= DirH;
      origin_q   <= '0;
      count_q    <= '0;
      mover_q    <= CellEmpty;
      win_q      <= 1'b0;
      board      <= '0;
      turn       <= 1'b0;
      game_over  <= 1'b0;
      winner     <= WinNone;
      move_ready <= 1'b1;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (move_valid) begin
            if (illegal) begin
              move_err <= 1'b1;
            end else begin
              board[2*int'(position) +: 2] <= player_code;
              origin_q   <= position;
              mover_q    <= player_code;
              count_q    <= count_q + CNT_W'(1);
              turn       <= ~turn;
              move_ack   <= 1'b1;
              move_ready <= 1'b0;
              dir_q      <= DirH;
              win_q      <= 1'b0;
              state_q    <= StCheck;
            end
          end
        end
        StCheck: begin
          win_q <= win_now;
          dir_q <= dir_q + 2'd1;
          if (dir_q == DirAnti) begin
            if (win_now) begin
              state_q   <= StOver;
              game_over <= 1'b1;
              winner    <= mover_q;
            end else if (count_q == CNT_W'(N*N)) begin
              state_q   <= StOver;
              game_over <= 1'b1;
              winner    <= WinDraw;
            end else begin
              state_q    <= StIdle;
              move_ready <= 1'b1;
            end
          end
        end
        StOver: begin
          if (move_valid) move_err <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
